// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoreboard.
// Holds the game state enum, the default win score and special segment glyphs.
// Segment constants are active-low in {g,f,e,d,c,b,a} order.
package pong_pkg;

  typedef enum logic [0:0] {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } state_t;

  localparam int WIN_SCORE_DEF = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/pong_scoreboard_if.sv
// Bundle between the drawing stage / board I/O and the scoreboard.
// Master drives wall-hit levels and new_game; slave returns scores and display.
// Plain level signals, no handshake: the scoreboard samples every clock.
interface pong_scoreboard_if;
  logic       right_hit;
  logic       left_hit;
  logic       new_game;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       winner;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output right_hit, left_hit, new_game,
    input  score_p1, score_p2, game_over, winner, seg, an
  );

  modport slave (
    input  right_hit, left_hit, new_game,
    output score_p1, score_p2, game_over, winner, seg, an
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment glyph {g,f,e,d,c,b,a}.
// Zero latency; decimal digits 0-9, anything else is blank.
// No flow control.
module seg7_decode
  import pong_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Standard decimal glyph table.
  always_comb begin
    seg = SEG_BLANK;
    case (val)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/pong_scoreboard.sv
// Two-player pong scoring, winner detection and 4-digit multiplexed display.
// Scores update on the edge a hit is first seen; seg/an lag digit_sel by one edge.
// No backpressure: hit levels are edge-detected every clock.
module pong_scoreboard
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int REFRESH_DIV = 6250
) (
  input  logic             clk,
  input  logic             reset,
  pong_scoreboard_if.slave bus
);

  localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);
  localparam int         CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t           state, state_nxt;
  logic [3:0]       score_p1, score_p1_nxt;
  logic [3:0]       score_p2, score_p2_nxt;
  logic             winner, winner_nxt;
  logic             right_q, left_q;
  logic             right_ev, left_ev;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_sel;
  logic [3:0]       digit_val;
  logic             digit_is_p;
  logic [6:0]       seg_dec;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  // Hit history always tracks the inputs, so a level held through reset never scores.
  always_ff @(posedge clk) begin
    right_q <= bus.right_hit;
    left_q  <= bus.left_hit;
  end

  assign right_ev = bus.right_hit & ~right_q;
  assign left_ev  = bus.left_hit  & ~left_q;

  // Game state and score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PLAY;
      score_p1 <= 4'd0;
      score_p2 <= 4'd0;
      winner   <= 1'b0;
    end else begin
      state    <= state_nxt;
      score_p1 <= score_p1_nxt;
      score_p2 <= score_p2_nxt;
      winner   <= winner_nxt;
    end
  end

  // Scoring and win detection; simultaneous hits cancel each other.
  always_comb begin
    state_nxt    = state;
    score_p1_nxt = score_p1;
    score_p2_nxt = score_p2;
    winner_nxt   = winner;
    case (state)
      PLAY: begin
        if (right_ev && !left_ev) begin
          score_p1_nxt = score_p1 + 4'd1;
          if (score_p1_nxt == WIN_VAL) begin
            state_nxt  = GAME_OVER;
            winner_nxt = 1'b0;
          end
        end else if (left_ev && !right_ev) begin
          score_p2_nxt = score_p2 + 4'd1;
          if (score_p2_nxt == WIN_VAL) begin
            state_nxt  = GAME_OVER;
            winner_nxt = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (bus.new_game) begin
          state_nxt    = PLAY;
          score_p1_nxt = 4'd0;
          score_p2_nxt = 4'd0;
          winner_nxt   = 1'b0;
        end
      end
    endcase
  end

  // Refresh divider stepping the digit selector once per REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Digit content mux; 4'hF decodes to blank.
  always_comb begin
    digit_val  = 4'hF;
    digit_is_p = 1'b0;
    case (digit_sel)
      2'd3: digit_val = score_p1;
      2'd0: digit_val = score_p2;
      2'd2: digit_is_p = (state == GAME_OVER);
      2'd1: if (state == GAME_OVER) digit_val = winner ? 4'd2 : 4'd1;
    endcase
  end

  seg7_decode u_dec (
    .val (digit_val),
    .seg (seg_dec)
  );

  // Register segments and anodes together so they always match.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_ZERO;
      an_q  <= 4'b1110;
    end else begin
      seg_q <= digit_is_p ? SEG_P : seg_dec;
      an_q  <= ~(4'b0001 << digit_sel);
    end
  end

  assign bus.score_p1  = score_p1;
  assign bus.score_p2  = score_p2;
  assign bus.game_over = (state == GAME_OVER);
  assign bus.winner    = winner;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_pong_scoreboard.sv
// Directed bench for pong_scoreboard with WIN_SCORE=5 and a fast refresh divider.
// Inputs change 1 time unit after the rising edge; outputs sampled at the same point.
// Ends with a single summary line.
module tb_pong_scoreboard;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pong_scoreboard_if bus ();

  pong_scoreboard #(
    .WIN_SCORE   (5),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_right();
    bus.right_hit = 1'b1; tick();
    bus.right_hit = 1'b0; tick();
  endtask

  task automatic pulse_left();
    bus.left_hit = 1'b1; tick();
    bus.left_hit = 1'b0; tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_p1"},   bus.score_p1, 0);
    chk({pfx, "_p2"},   bus.score_p2, 0);
    chk({pfx, "_go"},   bus.game_over, 0);
    chk({pfx, "_win"},  bus.winner, 0);
    chk({pfx, "_an"},   bus.an, 4'b1110);
    chk({pfx, "_seg"},  bus.seg, 7'b1000000);
  endtask

  initial begin
    logic [3:0] prev_an;
    int         last_chg;
    bit         seen_p, seen_w;

    reset         = 1'b1;
    bus.right_hit = 1'b0;
    bus.left_hit  = 1'b0;
    bus.new_game  = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Held hit scores once.
    bus.right_hit = 1'b1;
    tick(); chk("hold_e1", bus.score_p1, 1);
    tick(); chk("hold_e2", bus.score_p1, 1);
    tick(); chk("hold_e3", bus.score_p1, 1);
    bus.right_hit = 1'b0; tick();

    // Simultaneous rise cancels.
    bus.right_hit = 1'b1; bus.left_hit = 1'b1;
    tick();
    chk("both_p1", bus.score_p1, 1);
    chk("both_p2", bus.score_p2, 0);
    bus.right_hit = 1'b0; bus.left_hit = 1'b0; tick();

    pulse_right(); pulse_right();
    chk("p1_three", bus.score_p1, 3);

    // Display scan with p1=3, p2=0 in PLAY.
    prev_an  = bus.an;
    last_chg = -1;
    for (int c = 0; c < 24; c++) begin
      tick();
      case (bus.an)
        4'b1110: chk("seg_d0", bus.seg, 7'b1000000);
        4'b1101: chk("seg_d1_blank", bus.seg, 7'h7F);
        4'b1011: chk("seg_d2_blank", bus.seg, 7'h7F);
        4'b0111: chk("seg_d3", bus.seg, 7'b0110000);
        default: chk("an_onecold", bus.an, 4'b1110);
      endcase
      if (bus.an != prev_an) begin
        chk("an_rot", bus.an, {prev_an[2:0], prev_an[3]});
        if (last_chg >= 0) chk("an_period", c - last_chg, 4);
        last_chg = c;
      end
      prev_an = bus.an;
    end

    // new_game in PLAY does nothing.
    bus.new_game = 1'b1; tick();
    bus.new_game = 1'b0;
    chk("ng_play_p1", bus.score_p1, 3);
    chk("ng_play_go", bus.game_over, 0);

    // Player 2 wins.
    for (int i = 1; i <= 5; i++) begin
      bus.left_hit = 1'b1; tick();
      chk("p2_count", bus.score_p2, i);
      chk("p2_go", bus.game_over, (i == 5) ? 1 : 0);
      bus.left_hit = 1'b0; tick();
    end
    chk("win_who", bus.winner, 1);

    pulse_right();
    chk("frozen_p1", bus.score_p1, 3);
    chk("frozen_p2", bus.score_p2, 5);

    // GAME_OVER glyphs.
    seen_p = 1'b0; seen_w = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.an == 4'b1011) begin seen_p = 1'b1; chk("go_seg_p", bus.seg, 7'b0001100); end
      if (bus.an == 4'b1101) begin seen_w = 1'b1; chk("go_seg_win", bus.seg, 7'b0100100); end
    end
    chk("go_p_seen", seen_p, 1);
    chk("go_w_seen", seen_w, 1);

    // Leave GAME_OVER.
    bus.new_game = 1'b1; tick();
    bus.new_game = 1'b0;
    chk("ng_p1", bus.score_p1, 0);
    chk("ng_p2", bus.score_p2, 0);
    chk("ng_go", bus.game_over, 0);
    chk("ng_win", bus.winner, 0);

    // Hit held across reset must not score.
    bus.right_hit = 1'b1;
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick(); tick();
    chk("rst_hold_p1", bus.score_p1, 0);
    bus.right_hit = 1'b0; tick();

    // Mid-game reset.
    pulse_right(); pulse_right();
    pulse_left(); pulse_left(); pulse_left();
    chk("mid_p1", bus.score_p1, 2);
    chk("mid_p2", bus.score_p2, 3);
    reset = 1'b1; tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    chk("refresh_hold", bus.an, 4'b1110);
    tick();
    chk("refresh_step", bus.an, 4'b1101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_scoreboard.md
# pong_scoreboard

Downstream consumer of the ball/paddle drawing stage's `right_hit` / `left_hit` wall-hit flags. It keeps both players' scores and detects the match winner. It drives the board's 4-digit multiplexed 7-segment display, replacing the single-player LED counter. Runs in the pixel-clock domain alongside the drawing stage.

## Interface
Parameters:
- `WIN_SCORE`, 5 — points needed to win; legal range 1..9.
- `REFRESH_DIV`, 6250 — clocks per displayed digit (25 MHz pixel clock, ≈1 kHz per digit).

Ports (one clock; reset is synchronous and active-high):
- `clk` — input, 1 — pixel clock; all logic on rising edge.
- `reset` — input, 1 — synchronous, active-high.
- `right_hit` — input, 1 — level from drawing stage; high while ball is at right wall, so player 1 scores.
- `left_hit` — input, 1 — level; ball at left wall, so player 2 scores.
- `new_game` — input, 1 — level (btnC); leaves GAME_OVER.
- `score_p1` — output, 4 — player 1 score.
- `score_p2` — output, 4 — player 2 score.
- `game_over` — output, 1 — high in GAME_OVER.
- `winner` — output, 1 — 0 = player 1, 1 = player 2; valid only while `game_over` is high.
- `seg` — output, 7 — segments {g,f,e,d,c,b,a}, active-low.
- `an` — output, 4 — digit anodes, active-low; `an[3]` is the leftmost digit.

## Operation
- Edge detect: `hit_q` registers each hit input. A score event is `hit & ~hit_q`.
  - Holding a hit high scores exactly once.
  - While `reset` is high, `hit_q` loads the current input, so an input already high at reset release does not count.
- State PLAY:
  - A right event increments `score_p1`; a left event increments `score_p2`.
  - Both events in the same cycle: neither scores (ignored).
  - If the increment makes a score equal `WIN_SCORE`: go to GAME_OVER on the same edge, set `winner`, and assert `game_over`.
- State GAME_OVER:
  - Hit events are ignored and scores are frozen.
  - `new_game` high: go to PLAY, both scores cleared to 0, `winner` cleared to 0.
- `new_game` in PLAY has no effect.
- Scores never exceed `WIN_SCORE`; no wrap.
- Display refresh:
  - `refresh_cnt` counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, `digit_sel` (2 bits) increments, wrapping 3→0.
  - `an` = one-cold of `digit_sel`.
- Digit content:
  - `digit_sel` 3: `score_p1`.
  - `digit_sel` 0: `score_p2`.
  - `digit_sel` 2: blank (7'h7F) in PLAY; 'P' (7'b0001100) in GAME_OVER.
  - `digit_sel` 1: blank in PLAY; winner number '1' (7'b1111001) or '2' (7'b0100100) in GAME_OVER.
- Digit encodings:
  - '0' = 7'b1000000, '1' = 7'b1111001, '5' = 7'b0010010.
  - Values 0–9 use standard decimal glyphs.

## Timing
- All outputs are registered.
- Reset values:
  - Scores 0, `game_over` 0, `winner` 0, state PLAY.
  - `refresh_cnt` 0, `digit_sel` 0, `an` = 4'b1110, `seg` = 7'b1000000.
- Score latency: hit first sampled high at edge N means the score updates at edge N, visible from then on.
- `game_over` rises at the same edge as the winning score update.
- `new_game` sampled high at edge M in GAME_OVER: scores are 0 and `game_over` is 0 after edge M.
- `seg` and `an` update together at the edge after `digit_sel` changes, so there is no mismatched digit/anode cycle.
- Reset mid-game clears everything at the next edge regardless of state; the refresh counter restarts.

## Structure
- Shared package `pong_pkg` holds:
  - The state enum: PLAY, GAME_OVER.
  - Default `WIN_SCORE`.
  - Segment constants: SEG_BLANK, SEG_P.
- Sub-module `seg7_decode`: combinational 4-bit value → active-low 7-segment map (0–9, others blank).
  - Instantiated once, after the digit mux and before the output register.

## Test plan
- Reset, then pulse `right_hit` 3 cycles high → `score_p1` = 1 after the first edge; stays 1 across the held cycles.
- `left_hit` and `right_hit` rise in the same cycle → both scores unchanged.
- 5 separate `left_hit` pulses (`WIN_SCORE` = 5):
  - `score_p2` = 5, `game_over` = 1, `winner` = 1 on the 5th event's edge.
  - A further `right_hit` pulse leaves `score_p1` unchanged.
- In GAME_OVER, pulse `new_game` → next cycle scores 0, `game_over` 0. `new_game` asserted in PLAY → no change.
- Run with `REFRESH_DIV` = 4, `score_p1` = 3, `score_p2` = 0 → `an` cycles 1110, 1101, 1011, 0111 every 4 clocks.
  - `seg` = 7'b1000000 on `an` 1110.
  - `seg` = 7'b0110000 on `an` 0111.
  - `seg` is blank on the middle two digits.
- Hold `right_hit` high through assertion and release of `reset` → no score after release. Asserting `reset` mid-game at score 2–3 → all outputs at reset values next edge.
